bip_control_unit: RTL
=====================

# bip_control_unit

Instruction sequencer for the BIP processor. It owns the program counter, fetches one 16-bit instruction per slot from program memory, and decodes it into datapath strobes for the accumulator, ALU and data RAM. It runs one instruction every two clock cycles from `start_bip` until an HLT opcode. It sits between program memory and the accumulator/ALU/RAM datapath.

## Interface
Parameters:
- AB, 11, program/data address width; also the operand field width
- OPW, 5, opcode width; instruction width is OPW+AB
- CCW, 16, cycle counter width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_bip  in  1  run request, level-sensitive, sampled only in IDLE
- instr  in  OPW+AB  program memory data at address `pc_addr`; combinational read
- pc_addr  out  AB  program counter, drives program memory address
- operand  out  AB  `ir[AB-1:0]`, immediate value or data RAM address
- sel_a  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU
- sel_b  out  1  ALU B operand: 0 RAM, 1 immediate
- op  out  1  ALU operation: 0 add, 1 subtract
- wr_acc  out  1  accumulator write strobe
- wr_ram  out  1  data RAM write strobe
- rd_ram  out  1  data RAM read enable
- busy  out  1  high in FETCH and EXEC
- halted  out  1  high in HALT
- cycle_count  out  CCW  run-cycle counter; present only with BIP_CYCLE_COUNT_EN

## Operation
- States are IDLE, FETCH, EXEC and HALT.
- IDLE: waits for `start_bip`. When `start_bip`=1, moves to FETCH.
- FETCH: `ir <= instr`, then moves to EXEC.
- EXEC: drives strobes decoded from `ir[AB+OPW-1:AB]`.
  - HLT 00000: moves to HALT. `pc_addr` is not incremented.
  - Any other opcode: `pc_addr <= pc_addr+1` modulo 2^AB, so 2^AB-1 wraps to 0. Then moves to FETCH.
- Decode in EXEC (strobes not listed are 0):
  - STO 00001: wr_ram.
  - LD 00010: rd_ram, sel_a=00, wr_acc.
  - LDI 00011: sel_a=01, wr_acc.
  - ADD 00100: rd_ram, sel_a=10, sel_b=0, op=0, wr_acc.
  - ADDI 00101: sel_a=10, sel_b=1, op=0, wr_acc.
  - SUB 00110: rd_ram, sel_a=10, sel_b=0, op=1, wr_acc.
  - SUBI 00111: sel_a=10, sel_b=1, op=1, wr_acc.
  - Opcodes 01000–11111: NOP. All strobes are 0 and the PC still increments.
- HALT: absorbing; only `rst_n`=0 leaves it.
- `start_bip` is ignored outside IDLE.

## Timing
- Reset (`rst_n`=0 at an edge): the following edge state is IDLE, `pc_addr`=0, `ir`=0, every output 0, `cycle_count`=0.
- Reset mid-instruction aborts the instruction. No strobe is asserted in the cycle after the reset edge.
- Strobes, `sel_a`, `sel_b` and `op` are Moore outputs of (state, ir). They are valid for the whole EXEC cycle and 0 in every other state.
- `operand` is registered and holds `ir[AB-1:0]` in all states.
- Latency: `start_bip` is sampled at edge N, giving FETCH in cycle N+1 and the first EXEC in cycle N+2. Throughput is one instruction per 2 cycles.
- `pc_addr` changes only on the edge that leaves EXEC. It is therefore stable during FETCH, when `instr` is sampled.
- `halted` rises on the edge that leaves the HLT EXEC. `busy` falls on the same edge.

## Configuration
- Macro `BIP_CYCLE_COUNT_EN`.
  - Defined: `cycle_count` port exists. It increments on every edge where the state is FETCH or EXEC, holds in IDLE and HALT, saturates at 2^CCW-1, and clears on reset.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `bip_pkg`: opcode constants (HLT…SUBI), state enum (IDLE=0, FETCH=1, EXEC=2, HALT=3), `sel_a` encodings (SEL_RAM, SEL_IMM, SEL_ALU), and the opcode field position.
- Sub-module `bip_decoder`: purely combinational, opcode in, {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram} out. Its outputs are gated to 0 outside EXEC in the parent.

## Test plan
- Reset, then `start_bip`=1 with program LDI 5; ADDI 3; STO 7; HLT:
  - EXECs at cycles 2, 4, 6, 8.
  - Strobes follow the decode list; `operand` reads 5, 3, 7.
  - `halted`=1 with `pc_addr`=3.
- LD 0x010; SUB 0x011: `rd_ram`=1 in both EXECs; `op`=0 then 1; `sel_a`=00 then 10, `sel_b`=0.
- Preload `pc_addr`=0x7FF with opcode 01010: NOP with no strobes, and `pc_addr` wraps to 0x000.
- `rst_n`=0 during an ADD EXEC: next cycle IDLE, `pc_addr`=0, all strobes 0. `start_bip` held 0 keeps it IDLE.
- In HALT, toggle `start_bip` for 10 cycles: state stays HALT and `pc_addr` is unchanged.
- With `BIP_CYCLE_COUNT_EN`, a 4-instruction program ending in HLT gives `cycle_count`=8 and then holds. Forcing CCW=3 with a long program saturates at 7.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg: shared constants and types for the BIP instruction sequencer.
// Opcode field of an instruction sits at ir[AB +: OPC_W], operand at ir[AB-1:0].
package bip_pkg;

  localparam int OPC_W = 5;   // opcode width the constants below are written for
  localparam int DEF_AB = 11; // default address / operand width

  // Opcode constants
  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_RAM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Datapath control bundle produced by the decoder
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode decode into datapath strobes.
// Outputs are raw; the parent gates them to zero outside EXEC.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode_i,
  output ctrl_t          ctrl_o
);

  // Map each opcode to its strobe pattern; HLT and the NOP range decode to all-zero.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    ctrl_o = '0;
    case (opcode_i)
      OPW'(OP_STO): begin
        ctrl_o.wr_ram = 1'b1;
      end
      OPW'(OP_LD): begin
        ctrl_o.rd_ram = 1'b1;
        ctrl_o.sel_a  = SEL_RAM;
        ctrl_o.wr_acc = 1'b1;
      end
      OPW'(OP_LDI): begin
        ctrl_o.sel_a  = SEL_IMM;
        ctrl_o.wr_acc = 1'b1;
      end
      OPW'(OP_ADD): begin
        ctrl_o.rd_ram = 1'b1;
        ctrl_o.sel_a  = SEL_ALU;
        ctrl_o.sel_b  = 1'b0;
        ctrl_o.op     = 1'b0;
        ctrl_o.wr_acc = 1'b1;
      end
      OPW'(OP_ADDI): begin
        ctrl_o.sel_a  = SEL_ALU;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.op     = 1'b0;
        ctrl_o.wr_acc = 1'b1;
      end
      OPW'(OP_SUB): begin
        ctrl_o.rd_ram = 1'b1;
        ctrl_o.sel_a  = SEL_ALU;
        ctrl_o.sel_b  = 1'b0;
        ctrl_o.op     = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      OPW'(OP_SUBI): begin
        ctrl_o.sel_a  = SEL_ALU;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.op     = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: BIP instruction sequencer (IDLE -> FETCH <-> EXEC -> HALT).
// Owns the program counter and instruction register; one instruction per two cycles.
// Optional run-cycle counter port enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int AB  = 11,
  parameter int OPW = 5,
  parameter int CCW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_bip,
  input  logic [OPW+AB-1:0] instr,
  output logic [AB-1:0]     pc_addr,
  output logic [AB-1:0]     operand,
  output logic [1:0]        sel_a,
  output logic              sel_b,
  output logic              op,
  output logic              wr_acc,
  output logic              wr_ram,
  output logic              rd_ram,
  output logic              busy,
  output logic              halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [CCW-1:0]    cycle_count
`endif
);

  state_e            state_q, state_d;
  logic [AB-1:0]     pc_q, pc_d;
  logic [OPW+AB-1:0] ir_q, ir_d;
  logic [OPW-1:0]    opcode;
  ctrl_t             dec_ctrl;
  ctrl_t             ctrl;

  assign opcode = ir_q[AB +: OPW];

  // State, PC and IR registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic: fetch latches the instruction, execute advances the PC unless HLT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (start_bip) state_d = FETCH;
      end
      FETCH: begin
        ir_d    = instr;
        state_d = EXEC;
      end
      EXEC: begin
        if (opcode == OPW'(OP_HLT)) begin
          state_d = HALT;
        end else begin
          pc_d    = pc_q + AB'(1); // wraps modulo 2^AB
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  bip_decoder #(
    .OPW (OPW)
  ) u_decoder (
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  // Moore outputs: decoded strobes are only visible during EXEC.
  always_comb begin
    ctrl = '0;
    if (state_q == EXEC) ctrl = dec_ctrl;
  end

  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign op      = ctrl.op;
  assign wr_acc  = ctrl.wr_acc;
  assign wr_ram  = ctrl.wr_ram;
  assign rd_ram  = ctrl.rd_ram;
  assign pc_addr = pc_q;
  assign operand = ir_q[AB-1:0];
  assign busy    = (state_q == FETCH) || (state_q == EXEC);
  assign halted  = (state_q == HALT);

`ifdef BIP_CYCLE_COUNT_EN
  logic [CCW-1:0] cnt_q;

  // Saturating count of cycles spent in FETCH or EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != {CCW{1'b1}})) begin
      cnt_q <= cnt_q + CCW'(1);
    end
  end

  assign cycle_count = cnt_q;
`endif

endmodule
